// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and types for the 640x480@60 Hz timing generator.
// Sync windows are derived here so the RTL never hard-codes pixel positions.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

    localparam coord_t H_MAX        = coord_t'(H_TOTAL - 1);
    localparam coord_t V_MAX        = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_END    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END    = coord_t'(V_VISIBLE);
    localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bundle_t;

    // Inactive level: syncs idle high, blank low (no active video).
    localparam sync_bundle_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the drawers and VGA pins.
// No handshake: every signal is valid on every vga_clk cycle, master drives, slave samples.
interface vga_timing_if
    import vga_timing_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
);
    coord_t                 DrawX;
    coord_t                 DrawY;
    logic                   hs;
    logic                   vs;
    logic                   blank;
    logic                   sync;
    logic                   frame_start;
    logic [FRAME_CNT_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, hs, vs, blank, sync, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, hs, vs, blank, sync, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// DEPTH-stage shift register for the {hs,vs,blank} bundle; DEPTH=0 is a wire.
// Reset fills every stage with RESET_VAL so no stale sync pulse leaks out.
module vga_sync_delay #(
    parameter int         DEPTH     = 2,
    parameter logic [2:0] RESET_VAL = 3'b110
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [2:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing: registered DrawX/DrawY, delayed hs/vs/blank,
// and an undelayed per-frame strobe with a wrapping frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIPE_DELAY  = 2,
    parameter int FRAME_CNT_W = 16
) (
    input  logic         vga_clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    coord_t                 hc_q, hc_d;
    coord_t                 vc_q, vc_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   frame_start;
    sync_bundle_t           sync_raw;
    sync_bundle_t           sync_dly;

    // >= rather than == so any stray value still folds back to 0 at the wrap.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q >= H_MAX) begin
            hc_d = '0;
            vc_d = (vc_q >= V_MAX) ? '0 : vc_q + 10'd1;
        end
    end

    // Gated by reset so the strobe first fires on the cycle reset drops.
    assign frame_start   = (hc_q == '0) && (vc_q == '0) && !reset;
    assign frame_count_d = frame_start ? frame_count_q + FRAME_CNT_W'(1) : frame_count_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_count_q <= '0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        sync_raw.hs    = !in_window(hc_q, H_SYNC_START, H_SYNC_END);
        sync_raw.vs    = !in_window(vc_q, V_SYNC_START, V_SYNC_END);
        sync_raw.blank = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
    end

    vga_sync_delay #(
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk_i (vga_clk),
        .rst_i (reset),
        .d_i   (sync_raw),
        .q_o   (sync_dly)
    );

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.hs          = sync_dly.hs;
    assign vga.vs          = sync_dly.vs;
    assign vga.blank       = sync_dly.blank;
    assign vga.sync        = 1'b0;
    assign vga.frame_start = frame_start;
    assign vga.frame_count = frame_count_q;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz display path. It produces the DrawX/DrawY pixel coordinates that sprite and background drawers consume. It also produces hs/vs/blank, delayed to line up with the drawers' registered RGB outputs, plus a per-frame strobe and counter for game logic. It runs entirely in the vga_clk (25 MHz pixel clock) domain and sits between the clock source and every drawer feeding the VGA pins.

## Interface
- PIPE_DELAY, 2: cycles of delay applied to hs, vs, blank and sync relative to DrawX/DrawY. Covers 1 cycle of ROM read plus 1 cycle of RGB register. Legal range 0..7.
- FRAME_CNT_W, 16: width of frame_count.
- vga_clk  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- DrawX  out  10  current horizontal count, 0..799; values 0..639 are visible.
- DrawY  out  10  current vertical count, 0..524; values 0..479 are visible.
- hs  out  1  horizontal sync, active-low, delayed PIPE_DELAY cycles.
- vs  out  1  vertical sync, active-low, delayed PIPE_DELAY cycles.
- blank  out  1  1 = active video (drawers output palette colour), 0 = blanking; delayed PIPE_DELAY cycles.
- sync  out  1  composite sync for the DAC; tied to 0.
- frame_start  out  1  one-cycle pulse in the cycle where DrawX=0 and DrawY=0. Undelayed.
- frame_count  out  FRAME_CNT_W  increments on each frame_start; wraps modulo 2^FRAME_CNT_W.

## Operation
- Horizontal counter hc runs 0..799 and returns to 0 after 799.
- Vertical counter vc increments only when hc=799, runs 0..524, and returns to 0 when hc=799 and vc=524.
- DrawX=hc and DrawY=vc, both registered outputs.
- Raw (undelayed) signals:
  - hs_raw = 0 for hc in 656..751, else 1.
  - vs_raw = 0 for vc in 490..491, else 1.
  - blank_raw = 1 for hc<640 and vc<480, else 0.
- Horizontal line: visible 640, front porch 16, sync 96, back porch 48; total 800.
- Vertical frame: visible 480, front porch 10, sync 2, back porch 33; total 525.
- Delay line: hs_raw, vs_raw and blank_raw each pass through a PIPE_DELAY-stage shift register. With PIPE_DELAY=0 the outputs equal the raw signals combinationally from the registered counters.
- frame_start = 1 exactly when hc=0 and vc=0. frame_count increments in the same cycle frame_start is high, so the new value is visible on the next cycle.
- Counter widths: 10 bits each; there are no out-of-range states. If hc or vc is ever ≥ its maximum, it returns to 0 on the next wrap condition (defensive compare uses ≥).

## Timing
- Reset, held for any number of cycles, gives the following state on the cycle after reset samples 1:
  - hc=vc=0 and DrawX=DrawY=0.
  - hs=vs=1, blank=0, frame_start=0, frame_count=0.
  - Every delay-line stage is filled with inactive values (1 for hs/vs, 0 for blank).
- First cycle after reset deasserts: hc=0, vc=0, frame_start=1.
  - With PIPE_DELAY=2, blank first goes to 1 two cycles later.
- Reset asserted mid-frame aborts the frame immediately. There is no partial sync pulse beyond the flushed delay line: hs/vs are forced to 1 on the next cycle.
- Latency, with k = PIPE_DELAY:
  - Coordinate (x,y) on DrawX/DrawY at cycle t.
  - Matching blank/hs/vs at cycle t+k.
  - frame_start has 0 latency relative to DrawX/DrawY.
- Simultaneous hc wrap and vc wrap (hc=799, vc=524): both counters go to 0 in the same cycle, and frame_start asserts on that next cycle.
- Frame period is exactly 420000 cycles, and frame_start pulses exactly once per frame.
- frame_count wrap: at all-ones it goes to 0 on the next frame_start, with no stall.

## Structure
- Package vga_timing_pkg holds:
  - localparams H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800.
  - localparams V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
  - typedef coord_t as logic [9:0].
- Derived sync start/end constants are computed in the package, not hard-coded in RTL.
- One sub-module, vga_sync_delay: a parameterised DEPTH-stage shift register of a 3-bit {hs,vs,blank} bundle.
  - Has a RESET_VAL parameter.
  - DEPTH=0 is a pass-through.
  - Instantiated once in vga_timing_gen.

## Test plan
- Reset release, PIPE_DELAY=2:
  - Cycle 1 shows DrawX=0, DrawY=0, frame_start=1, hs=vs=1, blank=0.
  - blank=1 at cycle 3.
- Horizontal line: sample one line.
  - hs=0 for exactly 96 cycles, starting 2 cycles after DrawX=656.
  - blank=1 for exactly 640 cycles.
  - DrawX goes 799→0 and DrawY increments by 1.
- Full frame (420000 cycles):
  - vs=0 for exactly 1600 cycles, starting when delayed DrawY=490.
  - frame_start pulses once and frame_count goes 0→1.
- Corner wrap: at DrawX=799, DrawY=524, the next cycle gives DrawX=0, DrawY=0, frame_start=1.
- Mid-frame reset at DrawX=300, DrawY=200, held for 3 cycles:
  - During and after reset: outputs at reset values, delay line flushed.
  - Sequence restarts from (0,0).
- PIPE_DELAY=0 build: blank rises in the same cycle DrawX=0, DrawY=0.
- FRAME_CNT_W=2 build: frame_count sequence over 5 frames is 1,2,3,0,1.
